// File: rtl/sq_pkg.sv
// rtl/sq_pkg.sv - shared widths and state encoding for the odd-sum squarer
// Purpose: default operand/result widths and the FSM state type used by
//          odd_sum_squarer.
// Ports:   none (package)
package sq_pkg;

  localparam int N_W_DEF  = 4;
  localparam int SQ_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/odd_sum_step.sv
// rtl/odd_sum_step.sv - one accumulation step: add odd term, advance to next odd
// Purpose: combinational next-value unit for the odd-sum accumulator.
// Ports:   sq_i  running sum
//          k_i   current odd term
//          sq_o  sq_i + k_i
//          k_o   k_i + 2 (next odd number)
module odd_sum_step #(
  parameter int SQ_W = 9
) (
  input  logic [SQ_W-1:0] sq_i,
  input  logic [SQ_W-1:0] k_i,
  output logic [SQ_W-1:0] sq_o,
  output logic [SQ_W-1:0] k_o
);

  assign sq_o = sq_i + k_i;
  assign k_o  = k_i + SQ_W'(2);

endmodule

// File: rtl/odd_sum_squarer.sv
// rtl/odd_sum_squarer.sv - squares n by summing the first n odd numbers
// Purpose: go/busy/done handshake; one odd term accumulated per clock.
//          sq ends at n*n, count at n.
// Ports:   clk    rising-edge clock
//          reset  asynchronous active-high reset
//          go     start request, sampled only in IDLE
//          in     operand n, captured on the accepting edge
//          busy   high in ACCUM and DONE
//          done   one-cycle completion pulse
//          sq     accumulated result (held until the next accepted go)
//          count  odd terms accumulated so far
module odd_sum_squarer
  import sq_pkg::*;
#(
  parameter int N_W  = N_W_DEF,
  parameter int SQ_W = SQ_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            go,
  input  logic [N_W-1:0]  in,
  output logic            busy,
  output logic            done,
  output logic [SQ_W-1:0] sq,
  output logic [N_W-1:0]  count
);

  // The largest square and the largest odd term must both fit in SQ_W.
  if (SQ_W < 2 * N_W) begin : g_width_check
    $error("odd_sum_squarer: SQ_W must be at least 2*N_W");
  end

  state_t          state_q;
  logic [N_W-1:0]  n_q;
  logic [SQ_W-1:0] k_q;
  logic [SQ_W-1:0] sq_q;
  logic [N_W-1:0]  count_q;
  logic            busy_q;
  logic            done_q;

  logic [SQ_W-1:0] sq_d;
  logic [SQ_W-1:0] k_d;
  logic [N_W-1:0]  count_d;

  odd_sum_step #(
    .SQ_W (SQ_W)
  ) u_step (
    .sq_i (sq_q),
    .k_i  (k_q),
    .sq_o (sq_d),
    .k_o  (k_d)
  );

  assign count_d = count_q + N_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= SQ_W'(1);
      sq_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (go) begin
            n_q     <= in;
            sq_q    <= '0;
            count_q <= '0;
            k_q     <= SQ_W'(1);
            busy_q  <= 1'b1;
            // A zero operand has no terms to add: go straight to DONE.
            if (in != '0) begin
              state_q <= ACCUM;
              done_q  <= 1'b0;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        ACCUM: begin
          sq_q    <= sq_d;
          k_q     <= k_d;
          count_q <= count_d;
          if (count_d == n_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sq    = sq_q;
  assign count = count_q;

endmodule

// File: tb/tb_odd_sum_squarer.sv
// tb/tb_odd_sum_squarer.sv - self-checking bench for odd_sum_squarer
module tb_odd_sum_squarer;

  logic       clk;
  logic       reset;
  logic       go;
  logic [3:0] in;
  logic       busy;
  logic       done;
  logic [8:0] sq;
  logic [3:0] count;

  int checks;
  int errors;
  int cyc;

  int done_cyc[$];
  int done_sq[$];

  odd_sum_squarer #(
    .N_W  (4),
    .SQ_W (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .in    (in),
    .busy  (busy),
    .done  (done),
    .sq    (sq),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cyc.push_back(cyc);
      done_sq.push_back(int'(sq));
    end
  end

  // Reference: n*n from plain arithmetic; done visible n edges after accept.
  task automatic run_op(input int n, input bit noisy, input string name);
    int edges;
    bit seen;
    @(negedge clk);
    go = 1'b1;
    in = 4'(n);
    @(posedge clk);
    #1;
    go = 1'b0;
    in = 4'($urandom);
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_during_accum: got %b expected 1", name, busy);
        end
        if (noisy) begin
          go = 1'($urandom);
          in = 4'd3;
        end
        @(posedge clk);
        edges++;
      end
    end
    go = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: no done within 40 cycles", name);
    end else begin
      checks++;
      if (edges != n) begin
        errors++;
        $display("FAIL %s latency: got %0d edges expected %0d", name, edges, n);
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_at_done: got %b expected 1", name, busy);
      end
      checks++;
      if (sq !== 9'(n * n)) begin
        errors++;
        $display("FAIL %s sq: got %0d expected %0d", name, sq, n * n);
      end
      checks++;
      if (count !== 4'(n)) begin
        errors++;
        $display("FAIL %s count: got %0d expected %0d", name, count, n);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
    checks++;
    if (sq !== 9'(n * n)) begin
      errors++;
      $display("FAIL %s sq_hold: got %0d expected %0d", name, sq, n * n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go    = 1'b0;
    in    = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (sq !== 9'd0 || count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got sq=%0d count=%0d busy=%b done=%b expected 0 0 0 0",
               sq, count, busy, done);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op(8, 1'b0, "n8");
    run_op(0, 1'b0, "n0");
    run_op(15, 1'b0, "n15");
    run_op(1, 1'b0, "n1");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_op(int'($urandom_range(0, 15)), 1'b0, "random");
    end
  endtask

  task automatic test_ignore_go();
    run_op(5, 1'b1, "ignore_go");
  endtask

  task automatic test_abort();
    int pulses_before;
    pulses_before = done_cyc.size();
    @(negedge clk);
    go = 1'b1;
    in = 4'd7;
    @(posedge clk);
    #1;
    go = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (sq !== 9'd0 || count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear: got sq=%0d count=%0d busy=%b done=%b expected 0 0 0 0",
               sq, count, busy, done);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cyc.size() != pulses_before) begin
      errors++;
      $display("FAIL abort_no_done: got %0d pulses expected %0d",
               done_cyc.size(), pulses_before);
    end
    run_op(4, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back();
    int base;
    base = done_cyc.size();
    @(negedge clk);
    go = 1'b1;
    in = 4'd3;
    for (int i = 0; i < 40 && done_cyc.size() < base + 3; i++) begin
      @(negedge clk);
    end
    go = 1'b0;
    checks++;
    if (done_cyc.size() < base + 3) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d pulses expected 3", done_cyc.size() - base);
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (done_sq[base + j] != 9) begin
          errors++;
          $display("FAIL b2b_sq: got %0d expected 9", done_sq[base + j]);
        end
      end
      for (int j = 1; j < 3; j++) begin
        checks++;
        if (done_cyc[base + j] - done_cyc[base + j - 1] != 5) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d expected 5",
                   done_cyc[base + j] - done_cyc[base + j - 1]);
        end
      end
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_go();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
